// File: rtl/pattern_machine_pkg.sv
// Shared definitions for the serial pattern machines: parameter limits and the
// overlap-aware (KMP-style) transition function evaluated at elaboration.
package pattern_machine_pkg;

   localparam int PM_W_MIN  = 2;
   localparam int PM_W_MAX  = 8;
   localparam int PM_CW_MIN = 1;
   localparam int PM_CW_MAX = 16;

   // Next match length after seeing xb in state k. pat[w-1] is the first bit received.
   // A completed match restarts at 0 when overlap is off, otherwise at fail(w).
   function automatic int pm_next(int w, logic [7:0] pat, int k, logic xb, bit overlap);
      logic [8:0] s;
      int         best;
      bit         ok;
      best = 0;
      s    = '0;
      if (!overlap && (k == w - 1) && (xb == pat[0])) return 0;
      for (int j = 0; j < k; j++) s[4'(j)] = pat[3'(w - 1 - j)];
      s[4'(k)] = xb;
      for (int l = 1; (l <= k + 1) && (l < w); l++) begin
         ok = 1'b1;
         for (int i = 0; i < l; i++)
            if (pat[3'(w - 1 - i)] != s[4'(k + 1 - l + i)]) ok = 1'b0;
         if (ok) best = l;
      end
      return best;
   endfunction

endpackage

// File: rtl/pattern_machine_if.sv
// Serial input and status bundle between a stream source and a pattern machine.
interface pattern_machine_if #(
   parameter int SW = 2,
   parameter int CW = 4
);
   logic          en;
   logic          x;
   logic          clr;
   logic          F;
   logic [SW-1:0] S;
   logic          HIT;
   logic [CW-1:0] CNT;
   logic          SAT;

   modport master (output en, x, clr, input F, S, HIT, CNT, SAT);
   modport slave  (input en, x, clr, output F, S, HIT, CNT, SAT);
endinterface

// File: rtl/pattern_machine_dff_vec.sv
// Parametrised-width D register with asynchronous active-low reset to zero.
module dff_vec #(
   parameter int N = 1
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic [N-1:0] D,
   output logic [N-1:0] Q
);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) Q <= '0;
      else        Q <= D;
   end

endmodule

// File: rtl/pattern_machine.sv
// Serial pattern detector: match-length state, one-cycle match pulse, sticky hit
// flag and saturating hit counter, all driven straight from registers.
module pattern_machine
   import pattern_machine_pkg::*;
#(
   parameter int             W       = 4,
   parameter logic [W-1:0]   PATTERN = 4'b1011,
   parameter bit             OVERLAP = 1'b1,
   parameter int             CW      = 4
) (
   input  logic         CLK,
   input  logic         RESET,
   pattern_machine_if.slave bus
);

   localparam int SW = $clog2(W);

   if (W < PM_W_MIN || W > PM_W_MAX) begin : g_bad_w
      $error("pattern_machine: W out of range 2..8");
   end
   if (CW < PM_CW_MIN || CW > PM_CW_MAX) begin : g_bad_cw
      $error("pattern_machine: CW out of range 1..16");
   end

   // Transition table indexed by {state, x}; unreachable states map to 0.
   logic [SW-1:0] tbl [2**(SW+1)];
   for (genvar i = 0; i < 2**(SW+1); i++) begin : g_tbl
      localparam int K = i / 2;
      localparam int N = (K < W) ? pm_next(W, 8'(PATTERN), K, 1'(i % 2), OVERLAP) : 0;
      assign tbl[i] = SW'(N);
   end

   logic [SW-1:0] k_q, k_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          f_q, f_d;
   logic          hit_q, hit_d;
   logic          sat_q, sat_d;
   logic          match;

   assign match = bus.en && (k_q == SW'(W - 1)) && (bus.x == PATTERN[0]);

   assign k_d   = bus.clr ? '0 : (bus.en ? tbl[{k_q, bus.x}] : k_q);
   assign f_d   = !bus.clr && match;
   assign hit_d = !bus.clr && (hit_q || match);
   assign cnt_d = bus.clr ? '0 : ((match && !sat_q) ? cnt_q + CW'(1) : cnt_q);
   assign sat_d = &cnt_d;

   dff_vec #(.N(SW)) u_state (.CLK(CLK), .RESET(RESET), .D(k_d),   .Q(k_q));
   dff_vec #(.N(CW)) u_cnt   (.CLK(CLK), .RESET(RESET), .D(cnt_d), .Q(cnt_q));
   dff_vec #(.N(3))  u_flags (.CLK(CLK), .RESET(RESET),
                              .D({sat_d, hit_d, f_d}), .Q({sat_q, hit_q, f_q}));

   assign bus.F   = f_q;
   assign bus.S   = k_q;
   assign bus.HIT = hit_q;
   assign bus.CNT = cnt_q;
   assign bus.SAT = sat_q;

endmodule

// File: tb/tb_pattern_machine.sv
// Directed bench: four machine configurations share one serial stimulus stream.
module tb_pattern_machine;

   logic CLK = 1'b0;
   logic RESET = 1'b0;
   logic tb_en = 1'b0;
   logic tb_x = 1'b0;
   logic tb_clr = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 CLK = ~CLK;

   pattern_machine_if #(.SW(2), .CW(4)) ifa ();
   pattern_machine_if #(.SW(2), .CW(4)) ifb ();
   pattern_machine_if #(.SW(2), .CW(2)) ifc ();
   pattern_machine_if #(.SW(1), .CW(4)) ifd ();

   assign ifa.en = tb_en; assign ifa.x = tb_x; assign ifa.clr = tb_clr;
   assign ifb.en = tb_en; assign ifb.x = tb_x; assign ifb.clr = tb_clr;
   assign ifc.en = tb_en; assign ifc.x = tb_x; assign ifc.clr = tb_clr;
   assign ifd.en = tb_en; assign ifd.x = tb_x; assign ifd.clr = tb_clr;

   pattern_machine #(.W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CW(4))
      dut_a (.CLK(CLK), .RESET(RESET), .bus(ifa));
   pattern_machine #(.W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CW(4))
      dut_b (.CLK(CLK), .RESET(RESET), .bus(ifb));
   pattern_machine #(.W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CW(2))
      dut_c (.CLK(CLK), .RESET(RESET), .bus(ifc));
   pattern_machine #(.W(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CW(4))
      dut_d (.CLK(CLK), .RESET(RESET), .bus(ifd));

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic sbit(input logic b);
      tb_en = 1'b1; tb_x = b; tb_clr = 1'b0;
      tick();
   endtask

   task automatic idle();
      tb_en = 1'b0; tb_clr = 1'b0;
      tick();
   endtask

   task automatic do_clr();
      tb_en = 1'b0; tb_clr = 1'b1;
      tick();
      tb_clr = 1'b0;
   endtask

   task automatic test_reset();
      logic       xs [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic [1:0] es [4] = '{2'd1, 2'd2, 2'd3, 2'd1};
      logic       ef [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      tick(); tick();
      checks++; if (ifa.F !== 1'b0) begin failures++; $display("FAIL reset_F got=%0d exp=0", ifa.F); end
      checks++; if (ifa.S !== 2'd0) begin failures++; $display("FAIL reset_S got=%0d exp=0", ifa.S); end
      checks++; if (ifa.HIT !== 1'b0) begin failures++; $display("FAIL reset_HIT got=%0d exp=0", ifa.HIT); end
      checks++; if (ifa.CNT !== 4'd0) begin failures++; $display("FAIL reset_CNT got=%0d exp=0", ifa.CNT); end
      checks++; if (ifa.SAT !== 1'b0) begin failures++; $display("FAIL reset_SAT got=%0d exp=0", ifa.SAT); end
      RESET = 1'b1;
      sbit(1'b1); sbit(1'b0); sbit(1'b1); sbit(1'b1); sbit(1'b1); sbit(1'b0);
      checks++; if (ifa.S !== 2'd2) begin failures++; $display("FAIL pre_async_S got=%0d exp=2", ifa.S); end
      checks++; if (ifa.HIT !== 1'b1) begin failures++; $display("FAIL pre_async_HIT got=%0d exp=1", ifa.HIT); end
      checks++; if (ifa.CNT !== 4'd1) begin failures++; $display("FAIL pre_async_CNT got=%0d exp=1", ifa.CNT); end
      #2 RESET = 1'b0;
      #1;
      checks++; if (ifa.S !== 2'd0) begin failures++; $display("FAIL async_S got=%0d exp=0", ifa.S); end
      checks++; if (ifa.F !== 1'b0) begin failures++; $display("FAIL async_F got=%0d exp=0", ifa.F); end
      checks++; if (ifa.HIT !== 1'b0) begin failures++; $display("FAIL async_HIT got=%0d exp=0", ifa.HIT); end
      checks++; if (ifa.CNT !== 4'd0) begin failures++; $display("FAIL async_CNT got=%0d exp=0", ifa.CNT); end
      tb_en = 1'b0;
      #1 RESET = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         sbit(xs[i]);
         checks++; if (ifa.S !== es[i]) begin failures++; $display("FAIL post_reset_S[%0d] got=%0d exp=%0d", i, ifa.S, es[i]); end
         checks++; if (ifa.F !== ef[i]) begin failures++; $display("FAIL post_reset_F[%0d] got=%0d exp=%0d", i, ifa.F, ef[i]); end
      end
      idle();
      checks++; if (ifa.F !== 1'b0) begin failures++; $display("FAIL post_reset_F_drop got=%0d exp=0", ifa.F); end
   endtask

   task automatic test_overlap();
      logic       xs [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [1:0] es [7] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1};
      logic       ef [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      do_clr();
      checks++; if (ifa.CNT !== 4'd0) begin failures++; $display("FAIL ovl_clr_CNT got=%0d exp=0", ifa.CNT); end
      checks++; if (ifa.HIT !== 1'b0) begin failures++; $display("FAIL ovl_clr_HIT got=%0d exp=0", ifa.HIT); end
      for (int i = 0; i < 7; i++) begin
         sbit(xs[i]);
         checks++; if (ifa.S !== es[i]) begin failures++; $display("FAIL ovl_S[%0d] got=%0d exp=%0d", i, ifa.S, es[i]); end
         checks++; if (ifa.F !== ef[i]) begin failures++; $display("FAIL ovl_F[%0d] got=%0d exp=%0d", i, ifa.F, ef[i]); end
      end
      checks++; if (ifa.CNT !== 4'd2) begin failures++; $display("FAIL ovl_CNT got=%0d exp=2", ifa.CNT); end
      checks++; if (ifa.HIT !== 1'b1) begin failures++; $display("FAIL ovl_HIT got=%0d exp=1", ifa.HIT); end
      idle();
      checks++; if (ifa.F !== 1'b0) begin failures++; $display("FAIL ovl_F_drop got=%0d exp=0", ifa.F); end
   endtask

   task automatic test_nonoverlap();
      logic       xs [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [1:0] es [7] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1, 2'd1};
      logic       ef [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      do_clr();
      for (int i = 0; i < 7; i++) begin
         sbit(xs[i]);
         checks++; if (ifb.S !== es[i]) begin failures++; $display("FAIL novl_S[%0d] got=%0d exp=%0d", i, ifb.S, es[i]); end
         checks++; if (ifb.F !== ef[i]) begin failures++; $display("FAIL novl_F[%0d] got=%0d exp=%0d", i, ifb.F, ef[i]); end
      end
      checks++; if (ifb.CNT !== 4'd1) begin failures++; $display("FAIL novl_CNT got=%0d exp=1", ifb.CNT); end
   endtask

   task automatic test_mismatch();
      logic       xs [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [1:0] es [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd1};
      logic       ef [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      do_clr();
      for (int i = 0; i < 6; i++) begin
         sbit(xs[i]);
         checks++; if (ifa.S !== es[i]) begin failures++; $display("FAIL mis_S[%0d] got=%0d exp=%0d", i, ifa.S, es[i]); end
         checks++; if (ifa.F !== ef[i]) begin failures++; $display("FAIL mis_F[%0d] got=%0d exp=%0d", i, ifa.F, ef[i]); end
      end
      checks++; if (ifa.CNT !== 4'd1) begin failures++; $display("FAIL mis_CNT got=%0d exp=1", ifa.CNT); end
   endtask

   task automatic test_saturation();
      logic       xs [16] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                              1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [1:0] ec [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      logic       es [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      int         m = 0;
      int         pulses = 0;
      logic       ef;
      do_clr();
      for (int i = 0; i < 16; i++) begin
         sbit(xs[i]);
         ef = (i >= 3) && ((i % 3) == 0);
         if (ifc.F === 1'b1) pulses++;
         checks++; if (ifc.F !== ef) begin failures++; $display("FAIL sat_F[%0d] got=%0d exp=%0d", i, ifc.F, ef); end
         if (ef) begin
            checks++; if (ifc.CNT !== ec[m]) begin failures++; $display("FAIL sat_CNT[%0d] got=%0d exp=%0d", m, ifc.CNT, ec[m]); end
            checks++; if (ifc.SAT !== es[m]) begin failures++; $display("FAIL sat_SAT[%0d] got=%0d exp=%0d", m, ifc.SAT, es[m]); end
            m++;
         end
      end
      checks++; if (pulses !== 5) begin failures++; $display("FAIL sat_pulses got=%0d exp=5", pulses); end
   endtask

   task automatic test_clr_match();
      do_clr();
      sbit(1'b1); sbit(1'b0); sbit(1'b1); sbit(1'b1);
      checks++; if (ifa.HIT !== 1'b1) begin failures++; $display("FAIL clrm_pre_HIT got=%0d exp=1", ifa.HIT); end
      checks++; if (ifa.CNT !== 4'd1) begin failures++; $display("FAIL clrm_pre_CNT got=%0d exp=1", ifa.CNT); end
      sbit(1'b0); sbit(1'b1);
      checks++; if (ifa.S !== 2'd3) begin failures++; $display("FAIL clrm_pre_S got=%0d exp=3", ifa.S); end
      tb_en = 1'b1; tb_x = 1'b1; tb_clr = 1'b1;
      tick();
      tb_clr = 1'b0; tb_en = 1'b0;
      checks++; if (ifa.F !== 1'b0) begin failures++; $display("FAIL clrm_F got=%0d exp=0", ifa.F); end
      checks++; if (ifa.CNT !== 4'd0) begin failures++; $display("FAIL clrm_CNT got=%0d exp=0", ifa.CNT); end
      checks++; if (ifa.HIT !== 1'b0) begin failures++; $display("FAIL clrm_HIT got=%0d exp=0", ifa.HIT); end
      checks++; if (ifa.S !== 2'd0) begin failures++; $display("FAIL clrm_S got=%0d exp=0", ifa.S); end
   endtask

   task automatic test_en_gap();
      do_clr();
      sbit(1'b1); sbit(1'b0);
      checks++; if (ifa.S !== 2'd2) begin failures++; $display("FAIL gap_pre_S got=%0d exp=2", ifa.S); end
      for (int i = 0; i < 3; i++) begin
         tb_en = 1'b0; tb_x = ((i % 2) == 0);
         tick();
         checks++; if (ifa.S !== 2'd2) begin failures++; $display("FAIL gap_hold_S[%0d] got=%0d exp=2", i, ifa.S); end
         checks++; if (ifa.F !== 1'b0) begin failures++; $display("FAIL gap_hold_F[%0d] got=%0d exp=0", i, ifa.F); end
      end
      sbit(1'b1);
      checks++; if (ifa.S !== 2'd3) begin failures++; $display("FAIL gap_S3 got=%0d exp=3", ifa.S); end
      sbit(1'b1);
      checks++; if (ifa.F !== 1'b1) begin failures++; $display("FAIL gap_match_F got=%0d exp=1", ifa.F); end
      checks++; if (ifa.S !== 2'd1) begin failures++; $display("FAIL gap_match_S got=%0d exp=1", ifa.S); end
      idle();
      checks++; if (ifa.F !== 1'b0) begin failures++; $display("FAIL gap_en0_F got=%0d exp=0", ifa.F); end
      checks++; if (ifa.CNT !== 4'd1) begin failures++; $display("FAIL gap_en0_CNT got=%0d exp=1", ifa.CNT); end
   endtask

   task automatic test_back_to_back();
      logic ef [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      do_clr();
      for (int i = 0; i < 4; i++) begin
         sbit(1'b1);
         checks++; if (ifd.F !== ef[i]) begin failures++; $display("FAIL b2b_F[%0d] got=%0d exp=%0d", i, ifd.F, ef[i]); end
         checks++; if (ifd.S !== 1'b1) begin failures++; $display("FAIL b2b_S[%0d] got=%0d exp=1", i, ifd.S); end
      end
      checks++; if (ifd.CNT !== 4'd3) begin failures++; $display("FAIL b2b_CNT got=%0d exp=3", ifd.CNT); end
      sbit(1'b0);
      checks++; if (ifd.S !== 1'b0) begin failures++; $display("FAIL b2b_break_S got=%0d exp=0", ifd.S); end
      checks++; if (ifd.F !== 1'b0) begin failures++; $display("FAIL b2b_break_F got=%0d exp=0", ifd.F); end
   endtask

   initial begin
      test_reset();
      test_overlap();
      test_nonoverlap();
      test_mismatch();
      test_saturation();
      test_clr_match();
      test_en_gap();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
